// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Holds opcode constants, the FSM state enumeration, datapath select
// encodings and the one-hot instruction class produced by the decoder.
// The TRAP state only exists when RISCV_MC_ILLEGAL_TRAP_EN is defined.
package riscv_mc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    ST_TRAP   = 3'd5,
`endif
    ST_HALT   = 3'd6
  } state_e;

  // pc_src
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  // wb_sel
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // alu_src_a
  localparam logic [1:0] A_RS1    = 2'b00;
  localparam logic [1:0] A_PC_OLD = 2'b01;
  localparam logic [1:0] A_ZERO   = 2'b10;

  // alu_op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic r;
    logic i_alu;
    logic lui;
    logic auipc;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
  } instr_class_t;

endpackage

// File: rtl/riscv_main_decode.sv
// Opcode classifier: one-hot instruction class plus a legal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode (IR[6:0]) in; cls (one-hot class), legal out.
module riscv_main_decode
  import riscv_mc_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         legal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.r      = 1'b1;
      OP_I:      cls.i_alu  = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_AUIPC:  cls.auipc  = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      OP_JALR:   cls.jalr   = 1'b1;
      default:   cls        = '0;
    endcase
  end

  assign legal = |cls;

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Latency: 3 (BEQ), 4 (ALU/jump/SW), 5 (LW) cycles per instruction at zero wait.
// Backpressure: imem/dmem requests held until ready; TIMEOUT waits -> HALT.
// Ports: opcode, branch_taken, imem_ready, dmem_ready in; memory requests,
// datapath selects/enables, state, retired_cnt, bus_err, illegal_instr out.
// Optional feature macro: RISCV_MC_ILLEGAL_TRAP_EN (unknown opcodes trap
// instead of executing as a NOP).
module riscv_multicycle_control
  import riscv_mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             bus_err,
  output logic             illegal_instr
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_nxt;
  logic             run_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] ret_q;
  logic             bus_err_q;
  logic             waiting, timeout_hit, retire, trap_pulse;
  instr_class_t     cls;
  logic             legal;

  riscv_main_decode u_decode (
    .opcode (opcode),
    .cls    (cls),
    .legal  (legal)
  );

  // Next state, retirement and bus-wait detection.
  always_comb begin
    state_nxt = state_q;
    retire    = 1'b0;
    waiting   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) state_nxt = ST_DECODE;
        else            waiting   = 1'b1;
      end
      ST_DECODE: begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        state_nxt = legal ? ST_EXEC : ST_TRAP;
`else
        state_nxt = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        if (cls.load || cls.store) begin
          state_nxt = ST_MEM;
        end else if (cls.branch || !legal) begin
          // Branches and (in the NOP build) unknown opcodes finish here.
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (cls.store) begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = ST_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      ST_TRAP:  state_nxt = ST_FETCH;
`endif
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_HALT;
    endcase
    // A ready seen in the last allowed cycle clears waiting, so it wins.
    timeout_hit = waiting && (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    if (timeout_hit) state_nxt = ST_HALT;
  end

  // run_q holds the FSM idle for one edge after reset release so a ready
  // coinciding with the release is never taken as a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      run_q     <= 1'b0;
      wait_cnt  <= '0;
      ret_q     <= '0;
      bus_err_q <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= (waiting && !timeout_hit && (TIMEOUT != 0)) ? wait_cnt + WAIT_W'(1) : '0;
      if (retire)      ret_q     <= ret_q + CNT_W'(1);
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  // Datapath controls from the registered state and the current opcode.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_a  = A_RS1;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    trap_pulse = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        ST_EXEC: begin
          if (cls.r) alu_op = ALU_FUNCT;
          if (cls.i_alu) begin
            alu_src_b = 1'b1;
            alu_op    = ALU_FUNCT;
          end
          if (cls.lui) begin
            alu_src_a = A_ZERO;
            alu_src_b = 1'b1;
          end
          if (cls.auipc || cls.jal) begin
            alu_src_a = A_PC_OLD;
            alu_src_b = 1'b1;
          end
          if (cls.load || cls.store || cls.jalr) alu_src_b = 1'b1;
          if (cls.branch) begin
            alu_op   = ALU_SUB;
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
          end
          if (cls.jal || cls.jalr) begin
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end
          if (!legal) pc_write = 1'b1;
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls.store;
          pc_write = dmem_ready && cls.store;
        end
        ST_WB: begin
          reg_write = 1'b1;
          if (cls.load)                 wb_sel = WB_MEM;
          else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
          // Jumps already wrote the PC in EXEC.
          pc_write = !(cls.jal || cls.jalr);
        end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        ST_TRAP: begin
          pc_write   = 1'b1;
          pc_src     = PC_TRAP;
          trap_pulse = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign retired_cnt   = ret_q;
  assign bus_err       = bus_err_q;
  assign illegal_instr = trap_pulse;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
module tb_riscv_multicycle_control;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] ret;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [1:0]  a;
    logic        b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        ill;
    logic        berr;
  } exp_t;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3,
                         S_W = 3'd4, S_T = 3'd5, S_H = 3'd6;

  localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, LW = 7'b0000011, SW = 7'b0100011,
                         BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         BAD = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src_b;
  logic        reg_write, bus_err, illegal_instr;
  logic [1:0]  pc_src, alu_src_a, alu_op, wb_sel;
  logic [2:0]  state;
  logic [31:0] retired_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ret  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_multicycle_control #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .state(state), .retired_cnt(retired_cnt),
    .bus_err(bus_err), .illegal_instr(illegal_instr)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.ret = exp_ret;
    return e;
  endfunction

  task automatic pop_cmp(input string tag);
    exp_t x;
    x = sb.pop_front();
    chk_eq({tag, ".state"}, 64'(state), 64'(x.st));
    chk_eq({tag, ".ctrl"},
           64'({imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, wb_sel, illegal_instr, bus_err}),
           64'({x.imem_req, x.dmem_req, x.dmem_we, x.ir_write, x.pc_write, x.pc_src, x.a,
                x.b, x.alu_op, x.reg_write, x.wb_sel, x.ill, x.berr}));
    chk_eq({tag, ".ret"}, 64'(retired_cnt), 64'(x.ret));
  endtask

  // One clock cycle: drive inputs at the falling edge, compare 1ns later.
  task automatic step(input string tag, input exp_t e, input logic ir, input logic dr,
                      input logic bt);
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
    sb.push_back(e);
    #1;
    pop_cmp(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_ret = 0;
    step("rst", blank(S_F), 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    // Ready high during the release cycle must be ignored.
    step("rel", blank(S_F), 1'b1, 1'b1, 1'b0);
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {ADD, ADDI, LUI, AUIPC, LW, SW, BEQ, JAL, JALR};
  endfunction

  task automatic run_instr(input string nm, input logic [6:0] op, input int iw,
                           input int dw, input logic bt);
    exp_t e;
    opcode = op;
    for (int i = 0; i < iw; i++) begin
      e = blank(S_F); e.imem_req = 1'b1;
      step({nm, ".Fw"}, e, 1'b0, 1'b0, bt);
    end
    e = blank(S_F); e.imem_req = 1'b1; e.ir_write = 1'b1;
    step({nm, ".F"}, e, 1'b1, 1'b0, bt);
    step({nm, ".D"}, blank(S_D), 1'b0, 1'b0, bt);
    if (!is_legal(op)) begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      e = blank(S_T); e.pc_write = 1'b1; e.pc_src = 2'b11; e.ill = 1'b1;
      step({nm, ".T"}, e, 1'b0, 1'b0, bt);
`else
      e = blank(S_E); e.pc_write = 1'b1;
      step({nm, ".E"}, e, 1'b0, 1'b0, bt);
      exp_ret++;
`endif
      return;
    end
    e = blank(S_E);
    case (op)
      ADD:   e.alu_op = 2'b10;
      ADDI:  begin e.b = 1'b1; e.alu_op = 2'b10; end
      LUI:   begin e.a = 2'b10; e.b = 1'b1; end
      AUIPC: begin e.a = 2'b01; e.b = 1'b1; end
      LW, SW: e.b = 1'b1;
      BEQ:   begin e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = bt ? 2'b01 : 2'b00; end
      JAL:   begin e.a = 2'b01; e.b = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; end
      JALR:  begin e.b = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; end
      default: ;
    endcase
    step({nm, ".E"}, e, 1'b0, 1'b0, bt);
    if (op == BEQ) begin
      exp_ret++;
      return;
    end
    if (op == LW || op == SW) begin
      for (int i = 0; i < dw; i++) begin
        e = blank(S_M); e.dmem_req = 1'b1; e.dmem_we = (op == SW);
        step({nm, ".Mw"}, e, 1'b0, 1'b0, bt);
      end
      e = blank(S_M); e.dmem_req = 1'b1; e.dmem_we = (op == SW); e.pc_write = (op == SW);
      step({nm, ".M"}, e, 1'b0, 1'b1, bt);
      if (op == SW) begin
        exp_ret++;
        return;
      end
    end
    e = blank(S_W); e.reg_write = 1'b1;
    e.wb_sel   = (op == LW) ? 2'b01 : (op == JAL || op == JALR) ? 2'b10 : 2'b00;
    e.pc_write = !(op == JAL || op == JALR);
    step({nm, ".W"}, e, 1'b0, 1'b0, bt);
    exp_ret++;
  endtask

  initial begin
    exp_t e;
    @(negedge clk);
    do_reset();

    run_instr("add",   ADD,   0, 0, 1'b0);
    run_instr("lw",    LW,    0, 3, 1'b0);
    run_instr("beqT",  BEQ,   0, 0, 1'b1);
    run_instr("beqN",  BEQ,   0, 0, 1'b0);
    run_instr("jal",   JAL,   0, 0, 1'b0);
    run_instr("jalr",  JALR,  0, 0, 1'b0);
    run_instr("addi",  ADDI,  0, 0, 1'b0);
    run_instr("lui",   LUI,   0, 0, 1'b0);
    run_instr("auipc", AUIPC, 0, 0, 1'b0);
    run_instr("sw",    SW,    1, 2, 1'b0);
    // Ready in the last allowed wait cycle beats the timeout; counter
    // must restart from zero in MEM.
    run_instr("addW3", ADD,   3, 0, 1'b0);
    run_instr("lwW3",  LW,    3, 3, 1'b0);
    run_instr("bad",   BAD,   0, 0, 1'b0);
    run_instr("add2",  ADD,   0, 0, 1'b0);

    // Reset in the middle of a data access.
    opcode = LW;
    e = blank(S_F); e.imem_req = 1'b1; e.ir_write = 1'b1;
    step("mm.F", e, 1'b1, 1'b0, 1'b0);
    step("mm.D", blank(S_D), 1'b0, 1'b0, 1'b0);
    e = blank(S_E); e.b = 1'b1;
    step("mm.E", e, 1'b0, 1'b0, 1'b0);
    e = blank(S_M); e.dmem_req = 1'b1;
    step("mm.Mw", e, 1'b0, 1'b0, 1'b0);
    do_reset();
    run_instr("addR", ADD, 0, 0, 1'b0);

    // Instruction-bus timeout.
    for (int i = 0; i < 4; i++) begin
      e = blank(S_F); e.imem_req = 1'b1;
      step("to.Fw", e, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      e = blank(S_H); e.berr = 1'b1;
      step("to.H", e, 1'b1, 1'b1, 1'b0);
    end
    do_reset();
    run_instr("addH", ADD, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/riscv_multicycle_control.md
# riscv_multicycle_control

Multi-cycle control unit for the RV32I core: a registered FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath selects and enables, replacing the single-cycle opcode decoder. It adds valid/ready memory handshakes, a bus-wait timeout, a retired-instruction counter and JALR/AUIPC support, and sits between the instruction register and the shared datapath/memory port.

## Interface
- `TIMEOUT`, default 16: number of consecutive not-ready wait cycles before a bus error; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: `IR[6:0]`, valid from DECODE onward.
- `branch_taken` in 1: datapath compare result, valid in EXEC.
- `imem_ready` in 1: instruction memory ready.
- `dmem_ready` in 1: data memory ready.
- `imem_req` out 1: fetch request.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: data write enable (stores only).
- `ir_write` out 1: latch the instruction register and `pc_old`.
- `pc_write` out 1: update PC.
- `pc_src` out 2: PC source; 00 = PC+4, 01 = branch target, 10 = ALU result, 11 = trap vector.
- `alu_src_a` out 2: ALU A source; 00 = rs1, 01 = `pc_old`, 10 = zero.
- `alu_src_b` out 1: ALU B source; 0 = rs2, 1 = imm.
- `alu_op` out 2: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: writeback source; 00 = ALU, 01 = memory, 10 = `pc_old`+4.
- `state` out 3: current FSM state (debug).
- `retired_cnt` out `CNT_W`: retired-instruction count.
- `bus_err` out 1: sticky timeout error.
- `illegal_instr` out 1: one-cycle illegal-opcode pulse.

## Operation
- States are FETCH, DECODE, EXEC, MEM, WB, TRAP and HALT. Control outputs decode combinationally from the registered state and `opcode`.
- **FETCH:** `imem_req` is high.
  - On `imem_ready`: `ir_write` pulses and the FSM goes to DECODE.
- **DECODE:** always one cycle, then EXEC.
  - Exception: an unknown opcode goes to TRAP (see Configuration).
- **EXEC:**
  - R-type: `alu_op` 10, next state WB.
  - I-type ALU: `alu_src_b` 1, `alu_op` 10, next state WB.
  - LUI: A = zero, B = imm, next state WB.
  - AUIPC: A = `pc_old`, B = imm, next state WB.
  - LW/SW: A = rs1, B = imm, add, next state MEM.
  - BEQ: `alu_op` 01, `pc_write` = 1, `pc_src` = `branch_taken` ? 01 : 00. Next state FETCH; the instruction retires.
  - JAL: A = `pc_old`, B = imm, `pc_write` = 1, `pc_src` 10, next state WB.
  - JALR: A = rs1, B = imm, `pc_write` = 1, `pc_src` 10, next state WB.
- **MEM:** `dmem_req` is high; `dmem_we` is high for SW.
  - On `dmem_ready`, SW: `pc_write` with `pc_src` 00, next state FETCH; the instruction retires.
  - On `dmem_ready`, LW: next state WB.
- **WB:** one cycle, `reg_write` = 1, then FETCH; the instruction retires.
  - `wb_sel`: 01 for LW, 10 for JAL/JALR, otherwise 00.
  - `pc_write` with `pc_src` 00, except for JAL/JALR (PC already written in EXEC).
- **Retirement:** `retired_cnt` increments on the clock edge that leaves the retiring state and wraps modulo 2^`CNT_W`.
- **Timeout:** a wait counter counts consecutive cycles in FETCH or MEM with ready low. It clears on ready and on state entry.
  - When TIMEOUT not-ready cycles have elapsed, the next state is HALT and `bus_err` is set.
  - Ready high in the TIMEOUT-th cycle takes priority over the timeout.
- **HALT:** all request and enable outputs are 0. HALT is left only by reset.

## Timing
- Zero-wait latencies, FETCH entry to next FETCH entry:
  - BEQ: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR/SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds one cycle.
- `imem_req` / `dmem_req` are held high until ready is sampled high. The request drops in the cycle after the handshake.
- Reset:
  - While `rst_n` is low, all outputs are 0, `state` = FETCH, `retired_cnt` = 0, `bus_err` = 0, and the wait counter is 0.
  - `imem_req` rises in the first cycle after release.
  - Reset asserted mid-instruction abandons it immediately without retiring.
- When `rst_n` goes high in the same cycle as ready, the ready is ignored until FETCH is active.

## Configuration
- `RISCV_MC_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to TRAP for one cycle: `pc_write` = 1, `pc_src` = 11, `illegal_instr` = 1.
  - TRAP then goes to FETCH. The trapped instruction is not counted as retired.
- `RISCV_MC_ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode executes as a NOP: DECODE → EXEC → FETCH with `pc_src` 00, and it retires.
  - `illegal_instr` is tied to 0 and the TRAP state is absent.

## Structure
- Package `riscv_mc_pkg` holds:
  - opcode constants;
  - the state enumeration;
  - the `pc_src`, `wb_sel`, `alu_src_a` and `alu_op` encodings.
- Sub-module `riscv_main_decode`: combinational opcode classifier producing one-hot instruction class plus a legal flag. The FSM instantiates it once.

## Test plan
- ADD (0110011), ready always high → `state` sequence FETCH, DECODE, EXEC, WB; `reg_write` = 1 in WB only; `retired_cnt` 0 → 1 after 4 cycles.
- LW with `dmem_ready` low for 3 cycles → `dmem_req` high for 4 cycles; WB with `wb_sel` = 01; 8 cycles total.
- BEQ with `branch_taken` = 1 → EXEC asserts `pc_write`, `pc_src` = 01; back to FETCH after 3 cycles; no `reg_write`.
- JAL → EXEC `pc_src` = 10 with `alu_src_a` = 01; WB `wb_sel` = 10, `pc_write` = 0.
- TIMEOUT = 4, `imem_ready` held low → HALT after 4 wait cycles; `bus_err` = 1 sticky; all requests 0; reset clears it.
- Opcode 0000000 with the macro defined → TRAP, `pc_src` = 11, `illegal_instr` pulses once, `retired_cnt` unchanged.
- Opcode 0000000 without the macro → retires as a NOP in 3 cycles.
- Reset asserted mid-MEM → all outputs 0 immediately and `retired_cnt` = 0.
